// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
package i2c_arb_pkg;

  localparam int unsigned I2C_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    WAIT_BUSY,
    ACTIVE
  } arb_state_t;

  typedef struct packed {
    logic                  cmd_strobe;
    logic [I2C_BYTE_W-1:0] ctrl_wrd;
    logic [I2C_BYTE_W-1:0] len_read;
    logic                  data_available;
    logic [I2C_BYTE_W-1:0] data;
    logic                  ack_error;
  } i2c_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit at or above ptr, wrapping around.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master command interface among NUM_REQ requesters.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned PTR_W        = $clog2(NUM_REQ)
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            rq_req_i,
  output logic [NUM_REQ-1:0]            rq_gnt_o,
  input  logic [NUM_REQ-1:0]            rq_cmd_strobe_i,
  input  logic [NUM_REQ*I2C_BYTE_W-1:0] rq_ctrl_wrd_i,
  input  logic [NUM_REQ*I2C_BYTE_W-1:0] rq_len_read_i,
  input  logic [NUM_REQ-1:0]            rq_data_available_i,
  input  logic [NUM_REQ*I2C_BYTE_W-1:0] rq_data_i,
  input  logic [NUM_REQ-1:0]            rq_ack_error_i,
  output logic [NUM_REQ-1:0]            rq_read_data_o,
  output logic [NUM_REQ-1:0]            rq_collision_o,
  output logic [NUM_REQ-1:0]            rq_timeout_o,
  output logic                          i2c_cmd_strobe_o,
  output logic [I2C_BYTE_W-1:0]         i2c_ctrl_wrd_o,
  output logic [I2C_BYTE_W-1:0]         i2c_len_read_o,
  output logic                          i2c_data_available_o,
  output logic [I2C_BYTE_W-1:0]         i2c_data_o,
  output logic                          i2c_ack_error_o,
  input  logic                          i2c_read_data_i,
  input  logic                          i2c_busy_i,
  input  logic                          i2c_error_i,
  input  logic                          i2c_data_valid_i,
  input  logic [I2C_BYTE_W-1:0]         i2c_data_in_i,
  output logic [I2C_BYTE_W-1:0]         rq_data_o,
  output logic                          rq_data_valid_o,
  output logic                          rq_busy_o,
  output logic                          rq_error_o
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

  arb_state_t       state;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;
  logic [NUM_REQ-1:0] own;
  logic [NUM_REQ-1:0] coll_nxt;
  i2c_cmd_t         cmd_a [NUM_REQ];
  i2c_cmd_t         fwd;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cmd
    assign cmd_a[i] = '{
      cmd_strobe:     rq_cmd_strobe_i[i],
      ctrl_wrd:       rq_ctrl_wrd_i[i*I2C_BYTE_W +: I2C_BYTE_W],
      len_read:       rq_len_read_i[i*I2C_BYTE_W +: I2C_BYTE_W],
      data_available: rq_data_available_i[i],
      data:           rq_data_i[i*I2C_BYTE_W +: I2C_BYTE_W],
      ack_error:      rq_ack_error_i[i]
    };
  end

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (rq_req_i),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grantee routing; the strobe only passes while the grantee may start a command.
  always_comb begin
    fwd            = '0;
    rq_gnt_o       = '0;
    rq_read_data_o = '0;
    if (state != IDLE) begin
      fwd            = cmd_a[gidx];
      rq_gnt_o[gidx] = 1'b1;
      if (state != GRANTED) fwd.cmd_strobe = 1'b0;
      if (state == ACTIVE) rq_read_data_o[gidx] = i2c_read_data_i;
    end
  end

  assign own      = (state == GRANTED) ? rq_gnt_o : '0;
  assign coll_nxt = rq_cmd_strobe_i & ~own;
  assign nxt_ptr  = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);

  assign i2c_cmd_strobe_o     = fwd.cmd_strobe;
  assign i2c_ctrl_wrd_o       = fwd.ctrl_wrd;
  assign i2c_len_read_o       = fwd.len_read;
  assign i2c_data_available_o = fwd.data_available;
  assign i2c_data_o           = fwd.data;
  assign i2c_ack_error_o      = fwd.ack_error;

  assign rq_data_o       = i2c_data_in_i;
  assign rq_data_valid_o = i2c_data_valid_i;
  assign rq_busy_o       = i2c_busy_i;
  assign rq_error_o      = i2c_error_i;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state          <= IDLE;
      gidx           <= '0;
      rr_ptr         <= '0;
      cnt            <= '0;
      rq_collision_o <= '0;
      rq_timeout_o   <= '0;
    end else begin
      rq_collision_o <= coll_nxt;
      rq_timeout_o   <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gidx  <= pick_idx;
            state <= GRANTED;
          end
        end
        GRANTED: begin
          if (rq_cmd_strobe_i[gidx]) begin
            cnt   <= '0;
            state <= WAIT_BUSY;
          end else if (!rq_req_i[gidx]) begin
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end
        end
        WAIT_BUSY: begin
          if (i2c_busy_i) begin
            state <= ACTIVE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            rq_timeout_o[gidx] <= 1'b1;
            state              <= GRANTED;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (!i2c_busy_i) state <= GRANTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with an ownership-level reference model.
module tb_i2c_master_arbiter;

  localparam int N  = 2;
  localparam int BT = 16;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic         reset_i;
  logic [N-1:0] req, strb, dav, ackerr;
  logic [N*8-1:0] ctrl, len, wdat;
  logic         rd_i, busy, err, dval;
  logic [7:0]   din;

  logic [N-1:0] gnt, rdo, coll, tmo;
  logic         i2c_strb, i2c_dav, i2c_ack;
  logic [7:0]   i2c_ctrl, i2c_len, i2c_dat, rq_dat;
  logic         rq_dv, rq_busy, rq_err;

  int vectors     = 0;
  int miscompares = 0;

  i2c_master_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .rq_req_i             (req),
    .rq_gnt_o             (gnt),
    .rq_cmd_strobe_i      (strb),
    .rq_ctrl_wrd_i        (ctrl),
    .rq_len_read_i        (len),
    .rq_data_available_i  (dav),
    .rq_data_i            (wdat),
    .rq_ack_error_i       (ackerr),
    .rq_read_data_o       (rdo),
    .rq_collision_o       (coll),
    .rq_timeout_o         (tmo),
    .i2c_cmd_strobe_o     (i2c_strb),
    .i2c_ctrl_wrd_o       (i2c_ctrl),
    .i2c_len_read_o       (i2c_len),
    .i2c_data_available_o (i2c_dav),
    .i2c_data_o           (i2c_dat),
    .i2c_ack_error_o      (i2c_ack),
    .i2c_read_data_i      (rd_i),
    .i2c_busy_i           (busy),
    .i2c_error_i          (err),
    .i2c_data_valid_i     (dval),
    .i2c_data_in_i        (din),
    .rq_data_o            (rq_dat),
    .rq_data_valid_o      (rq_dv),
    .rq_busy_o            (rq_busy),
    .rq_error_o           (rq_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the master, and whether its command is awaiting busy or running.
  int           owner, ptr, age;
  bit           waiting, running, m_valid;
  logic [N-1:0] e_coll, e_tmo, eg, er;
  logic         estb;
  logic [26:0]  ebus;

  initial begin
    m_valid = 1'b0;
    owner   = -1;
    ptr     = 0;
    age     = 0;
    waiting = 1'b0;
    running = 1'b0;
    e_coll  = '0;
    e_tmo   = '0;
  end

  always @(negedge clock_i) begin
    if (m_valid) begin
      eg   = '0;
      er   = '0;
      ebus = '0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        estb = strb[owner] && !waiting && !running;
        ebus = {estb, ctrl[owner*8 +: 8], len[owner*8 +: 8], dav[owner],
                wdat[owner*8 +: 8], ackerr[owner]};
        if (running) er[owner] = rd_i;
      end
      chk("cyc_gnt", gnt, eg);
      chk("cyc_i2c_bus", {i2c_strb, i2c_ctrl, i2c_len, i2c_dav, i2c_dat, i2c_ack}, ebus);
      chk("cyc_read_data", rdo, er);
      chk("cyc_collision", coll, e_coll);
      chk("cyc_timeout", tmo, e_tmo);
      chk("cyc_broadcast", {rq_dat, rq_dv, rq_busy, rq_err}, {din, dval, busy, err});
    end
    if (!reset_i) begin
      owner   = -1;
      ptr     = 0;
      age     = 0;
      waiting = 1'b0;
      running = 1'b0;
      e_coll  = '0;
      e_tmo   = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      e_coll = strb;
      if (owner >= 0 && !waiting && !running) e_coll[owner] = 1'b0;
      e_tmo = '0;
      if (owner < 0) begin
        for (int k = 0; k < N; k++)
          if (owner < 0 && req[(ptr + k) % N]) owner = (ptr + k) % N;
      end else if (running) begin
        if (!busy) running = 1'b0;
      end else if (waiting) begin
        if (busy) begin
          waiting = 1'b0;
          running = 1'b1;
        end else if (age == BT - 1) begin
          e_tmo[owner] = 1'b1;
          waiting      = 1'b0;
        end else begin
          age++;
        end
      end else if (strb[owner]) begin
        waiting = 1'b1;
        age     = 0;
      end else if (!req[owner]) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic issue(input int g, input logic [7:0] c, input logic [7:0] l);
    ctrl[g*8 +: 8] = c;
    len[g*8 +: 8]  = l;
    strb[g]        = 1'b1;
    #1;
    chk("fwd_strobe", i2c_strb, 1'b1);
    chk("fwd_ctrl", i2c_ctrl, c);
    tick();
    strb[g] = 1'b0;
  endtask

  int n;

  initial begin
    reset_i = 1'b0;
    req     = 2'b11;
    strb    = '0;
    ctrl    = '0;
    len     = '0;
    dav     = '0;
    wdat    = '0;
    ackerr  = '0;
    rd_i    = 1'b0;
    busy    = 1'b0;
    err     = 1'b0;
    dval    = 1'b0;
    din     = '0;

    repeat (3) begin
      tick();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_strobe", i2c_strb, 1'b0);
    end
    reset_i = 1'b1;
    #1;
    chk("release_gnt", gnt, 2'b00);
    tick();
    chk("first_gnt", gnt, 2'b01);

    // EEPROM set-address, with a colliding strobe from requester 1 while active
    issue(0, 8'hA0, 8'h00);
    busy = 1'b1;
    tick();
    tick();
    strb[1] = 1'b1;
    ctrl[15:8] = 8'h90;
    #1;
    chk("coll_no_strobe", i2c_strb, 1'b0);
    chk("coll_ctrl_kept", i2c_ctrl, 8'hA0);
    tick();
    strb[1] = 1'b0;
    #1;
    chk("coll_pulse", coll, 2'b10);
    tick();
    chk("coll_clear", coll, 2'b00);
    tick();
    busy = 1'b0;
    tick();
    chk("hold_gnt", gnt, 2'b01);

    // EEPROM read of one byte
    issue(0, 8'hA1, 8'h01);
    busy = 1'b1;
    tick();
    din  = 8'h5A;
    dval = 1'b1;
    #1;
    chk("read_byte", rq_dat, 8'h5A);
    chk("read_valid", rq_dv, 1'b1);
    tick();
    dval = 1'b0;
    busy = 1'b0;
    tick();
    chk("still_gnt0", gnt, 2'b01);
    req[0] = 1'b0;
    tick();
    chk("drop_gap", gnt, 2'b00);
    tick();
    chk("gnt1", gnt, 2'b10);

    // Requester 1 write byte routing
    wdat[15:8] = 8'h3C;
    dav[1]     = 1'b1;
    issue(1, 8'h90, 8'h00);
    busy = 1'b1;
    tick();
    rd_i = 1'b1;
    #1;
    chk("route_read", rdo, 2'b10);
    chk("route_data", i2c_dat, 8'h3C);
    chk("route_dav", i2c_dav, 1'b1);
    tick();
    rd_i = 1'b0;
    busy = 1'b0;
    tick();
    req = 2'b01;
    tick();
    chk("gap1", gnt, 2'b00);
    req[1] = 1'b1;
    tick();

    // Alternating grants with both requesting
    for (int it = 0; it < 4; it++) begin
      chk("rr_order", gnt, (it % 2 == 0) ? 2'b01 : 2'b10);
      issue(it % 2, 8'hB0, 8'h00);
      busy = 1'b1;
      tick();
      tick();
      busy = 1'b0;
      tick();
      req[it % 2] = 1'b0;
      tick();
      chk("rr_gap", gnt, 2'b00);
      req[it % 2] = 1'b1;
      tick();
    end

    // Master never goes busy
    chk("tmo_gnt", gnt, 2'b01);
    issue(0, 8'hC0, 8'h00);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (tmo != '0) break;
    end
    chk("tmo_latency", n, 16);
    chk("tmo_bit", tmo, 2'b01);
    issue(0, 8'hC0, 8'h00);

    // Reset in the middle of a transaction
    busy = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    chk("midrst_gnt", gnt, 2'b00);
    chk("midrst_strobe", i2c_strb, 1'b0);
    reset_i = 1'b1;
    busy    = 1'b0;
    req     = '0;
    tick();
    tick();
    chk("post_rst_idle", gnt, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
